store_merge_rmw: RTL
====================

Name: store_merge_rmw

Overview:
- Write-side counterpart of the load sign/zero-extension path: takes a 32-bit register value plus a store size (word/half/byte) and produces the full 32-bit word written to word-organised memory.
- Word stores go straight through.
- Half and byte stores run a read-modify-write sequence: read the containing word, merge the stored lane, write the word back.
- Sits between the control unit (sw/sh/sb states) and the memory port mux.

Parameters:
READ_LATENCY, 1, cycles from mem_addr presented (mem_wr=0) until mem_rdata valid; legal 1..7

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low; sampled on rising edge of clk
start  input  1  request strobe; accepted only in IDLE
size  input  2  00 word, 01 half, 10 byte, 11 illegal
addr  input  32  byte address of the store
store_data  input  32  register value; low 8/16/32 bits stored
mem_rdata  input  32  memory read data
mem_addr  output  32  word address to memory, {addr_q[31:2],2'b00}
mem_wr  output  1  memory write enable, one cycle per accepted legal store
mem_wdata  output  32  word written to memory
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, store completed
misaligned  output  1  one-cycle pulse, request rejected, nothing written

Behaviour:
- Reset (reset=0 at a clk edge):
  - state IDLE; mem_addr, mem_wdata, internal regs = 0; mem_wr, busy, done, misaligned = 0.
  - Applies mid-sequence too: operation aborted, no write issued afterwards.
- States: IDLE, READ, WAIT, WRITE, DONE, ERR.
- IDLE: on start=1, latch addr, size, store_data into addr_q, size_q, data_q.
  - Alignment check on the latched request:
    - size 11 → illegal.
    - word with addr[1:0]≠00 → illegal.
    - half with addr[0]=1 → illegal.
  - illegal → ERR.
  - legal word → WRITE.
  - legal half/byte → READ.
- start while busy is ignored (not queued).
- READ, one cycle: mem_addr = word address, mem_wr=0. Load wait counter with READ_LATENCY-1. → WAIT.
- WAIT:
  - Counter nonzero: decrement, stay.
  - Counter zero: capture mem_rdata into merge register, → WRITE.
  - mem_addr held stable.
- WRITE, one cycle: mem_wr=1; mem_addr = word address; mem_wdata chosen as:
  - word: data_q.
  - half, addr_q[1]=0: {rd[31:16], data_q[15:0]}.
  - half, addr_q[1]=1: {data_q[15:0], rd[15:0]}.
  - byte, offset k=addr_q[1:0]: lane [8k+7:8k] = data_q[7:0]; other lanes from rd.
  - Then → DONE.
- DONE: done=1 for one cycle, → IDLE.
- ERR: misaligned=1 for one cycle, mem_wr stays 0, → IDLE.
- done and misaligned are never high together. mem_wr is high exactly one cycle per legal request.
- Lane order: little-endian, byte offset 0 = bits [7:0].
- Latency, start sampled at edge 0, READ_LATENCY=L:
  - word: WRITE in cycle 1, done in cycle 2.
  - half/byte: READ cycle 1, WAIT cycles 2..L+1, WRITE cycle L+2, done cycle L+3.
  - illegal: misaligned in cycle 1.
- Back-to-back: a new start is accepted in the cycle after DONE/ERR, i.e. the first cycle back in IDLE.
- Outputs are registered; mem_wdata holds its last value outside WRITE.

Test Plan:
- Word store: start, size=00, addr=0x100, store_data=0xDEADBEEF → mem_wr=1 one cycle later with mem_addr=0x100, mem_wdata=0xDEADBEEF; done the next cycle; no read cycle.
- Byte store, all offsets: memory word 0x11223344 at 0x200; sb 0xAB to 0x201 → mem_wdata=0x1122AB44. Offset 3 → 0xAB223344. Offset 0 → 0x112233AB. With L=1, done 4 cycles after start.
- Half store: word 0x11223344; sh store_data=0xFFFFCAFE to 0x202 → mem_wdata=0xCAFE3344. To 0x200 → 0x1122CAFE.
- Misaligned/illegal: sh to 0x201, sw to 0x102, size=11 → misaligned pulse one cycle after start; mem_wr never asserted; busy back to 0 next cycle.
- Latency sweep: READ_LATENCY=3, sb to 0x300 → mem_rdata sampled 3 cycles after READ; mem_wr at cycle 5, done at cycle 6. start pulsed during WAIT is ignored.
- Reset mid-op: assert reset=0 while in WAIT → next cycle all outputs 0, state IDLE, no mem_wr ever. A fresh sw after release completes normally.

Source files
------------

// File: rtl/store_merge_rmw.sv
// -----------------------------------------------------------------------------
// store_merge_rmw
//
// Store-side lane merger. This block takes a register value and a store size
// (word, half or byte) and produces the full 32-bit word that is written to
// word-organised memory.
//   - Word stores are written straight through.
//   - Half and byte stores do a read-modify-write: the block reads the
//     containing word, merges the stored lane into it, and writes it back.
//
// Ports
//   clk         rising-edge system clock
//   reset       synchronous, active-low reset
//   start       request strobe; only accepted in IDLE
//   size        00 word, 01 half, 10 byte, 11 illegal
//   addr        byte address of the store
//   store_data  register value; the low 8/16/32 bits are stored
//   mem_rdata   memory read data, valid READ_LATENCY cycles after mem_addr
//   mem_addr    word-aligned memory address (registered)
//   mem_wr      memory write enable, one cycle per legal store (registered)
//   mem_wdata   word written to memory; holds its value outside WRITE
//   busy        high in every state except IDLE
//   done        one-cycle pulse when a store completes
//   misaligned  one-cycle pulse when a request is rejected
//
// Parameter
//   READ_LATENCY  cycles from the read address to valid mem_rdata (1..7)
// -----------------------------------------------------------------------------
module store_merge_rmw #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [2:0] WAIT_LOAD = 3'(READ_LATENCY - 1);

    logic [2:0]  state,  state_n;
    logic [31:0] addr_q, addr_q_n;
    logic [1:0]  size_q, size_q_n;
    logic [31:0] data_q, data_q_n;
    logic [2:0]  cnt,    cnt_n;

    logic [31:0] mem_addr_n;
    logic        mem_wr_n;
    logic [31:0] mem_wdata_n;
    logic        busy_n;
    logic        done_n;
    logic        misaligned_n;

    // Returns 1 when a request cannot be performed: the size code is
    // reserved, or the address is not aligned to the access size.
    function automatic logic request_illegal(input logic [1:0]  sz,
                                             input logic [1:0]  off);
        logic bad;
        bad = 1'b0;
        case (sz)
            SZ_WORD: bad = (off != 2'b00);
            SZ_HALF: bad = off[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Inserts the stored lane into the word read from memory.
    // The lane order is little-endian: byte offset 0 is bits [7:0].
    function automatic logic [31:0] merge_word(input logic [1:0]  sz,
                                               input logic [1:0]  off,
                                               input logic [31:0] d,
                                               input logic [31:0] rd);
        logic [31:0] w;
        w = rd;
        case (sz)
            SZ_HALF: begin
                if (off[1]) w[31:16] = d[15:0];
                else        w[15:0]  = d[15:0];
            end
            SZ_BYTE: begin
                case (off)
                    2'd0:    w[7:0]   = d[7:0];
                    2'd1:    w[15:8]  = d[7:0];
                    2'd2:    w[23:16] = d[7:0];
                    default: w[31:24] = d[7:0];
                endcase
            end
            default: w = d;
        endcase
        return w;
    endfunction

    // Every output is registered. For this reason, the outputs are computed
    // here from the next state, and they appear in the same cycle as that
    // state. mem_wdata also serves as the merge register: the read word is
    // merged while it is captured, so that the WRITE cycle presents the
    // final word.
    always_comb begin
        state_n      = state;
        addr_q_n     = addr_q;
        size_q_n     = size_q;
        data_q_n     = data_q;
        cnt_n        = cnt;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        mem_wr_n     = 1'b0;
        done_n       = 1'b0;
        misaligned_n = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_q_n   = addr;
                    size_q_n   = size;
                    data_q_n   = store_data;
                    mem_addr_n = {addr[31:2], 2'b00};
                    if (request_illegal(size, addr[1:0])) begin
                        state_n      = S_ERR;
                        misaligned_n = 1'b1;
                    end else if (size == SZ_WORD) begin
                        state_n     = S_WRITE;
                        mem_wr_n    = 1'b1;
                        mem_wdata_n = store_data;
                    end else begin
                        state_n = S_READ;
                    end
                end
            end
            S_READ: begin
                cnt_n   = WAIT_LOAD;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (cnt != 3'd0) begin
                    cnt_n = cnt - 3'd1;
                end else begin
                    mem_wdata_n = merge_word(size_q, addr_q[1:0], data_q, mem_rdata);
                    mem_wr_n    = 1'b1;
                    state_n     = S_WRITE;
                end
            end
            S_WRITE: begin
                done_n  = 1'b1;
                state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            data_q     <= '0;
            cnt        <= '0;
            mem_addr   <= '0;
            mem_wr     <= 1'b0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_n;
            addr_q     <= addr_q_n;
            size_q     <= size_q_n;
            data_q     <= data_q_n;
            cnt        <= cnt_n;
            mem_addr   <= mem_addr_n;
            mem_wr     <= mem_wr_n;
            mem_wdata  <= mem_wdata_n;
            busy       <= busy_n;
            done       <= done_n;
            misaligned <= misaligned_n;
        end
    end

endmodule
